// File: rtl/lw_sha_round_ctrl.sv
// Round sequencer for the masked lightweight SHA-256/512 compression datapath.
// Optional macro LW_SHA_RAND_REFRESH_EN registers fresh a/e re-masking bits per round.
module lw_sha_round_ctrl #(
  parameter int W           = 32,
  parameter bit SUPPORT_512 = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            mode_i,
  input  logic [7:0][W:0] init_state_i,
  input  logic [W-1:0]    word_i,
  input  logic            word_valid_i,
  output logic            word_ready_o,
  input  logic [1:0]      rnd_i,
  output logic [7:0][W:0] rnd_state_o,
  output logic [6:0]      rnd_index_o,
  output logic [1:0]      rnd_random_o,
  input  logic [7:0][W:0] rnd_new_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [7:0][W:0] digest_o,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] LAST_256 = 7'd63;
  localparam logic [6:0] LAST_512 = 7'd79;

  state_t          fsm_q;
  logic [7:0][W:0] state_q;
  logic [6:0]      idx_q;
  logic            mode_q;
  logic [6:0]      last_idx;
  logic            start_load;
  logic            accept;

  // Handshake: a word is consumed on a cycle where word_valid_i and word_ready_o
  // are both 1 and abort_i is 0; word_ready_o is high only in ROUND and never
  // depends on word_valid_i.
  assign last_idx   = mode_q ? LAST_512 : LAST_256;
  assign start_load = (fsm_q == S_IDLE) & start_i & ~abort_i;
  assign accept     = word_valid_i & word_ready_o & ~abort_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q        <= S_IDLE;
      state_q      <= '0;
      idx_q        <= '0;
      mode_q       <= 1'b0;
      word_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (start_load) begin
            fsm_q        <= S_ROUND;
            state_q      <= init_state_i;
            idx_q        <= '0;
            mode_q       <= mode_i & SUPPORT_512;
            word_ready_o <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        S_ROUND: begin
          if (abort_i) begin
            fsm_q        <= S_IDLE;
            state_q      <= '0;
            idx_q        <= '0;
            word_ready_o <= 1'b0;
            busy_o       <= 1'b0;
          end else if (accept) begin
            state_q <= rnd_new_i;
            // The index saturates at the last round so it never wraps.
            if (idx_q == last_idx) begin
              fsm_q        <= S_DONE;
              word_ready_o <= 1'b0;
              done_o       <= 1'b1;
            end else begin
              idx_q <= idx_q + 7'd1;
            end
          end
        end
        S_DONE: begin
          fsm_q  <= S_IDLE;
          busy_o <= 1'b0;
          if (abort_i) begin
            state_q <= '0;
            idx_q   <= '0;
          end
        end
        default: begin
          fsm_q        <= S_IDLE;
          word_ready_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

  assign rnd_state_o = state_q;
  assign rnd_index_o = idx_q;
  assign digest_o    = state_q;
  assign dbg_state_o = fsm_q;

`ifdef LW_SHA_RAND_REFRESH_EN
  logic [1:0] rnd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rnd_q <= 2'b00;
    end else if (start_load || accept) begin
      rnd_q <= rnd_i;
    end
  end

  assign rnd_random_o = rnd_q;
`else
  logic unused_rnd;
  assign unused_rnd   = ^rnd_i;
  assign rnd_random_o = 2'b00;
`endif

  // The schedule word goes straight to the datapath; the controller only paces it.
  logic unused_word;
  assign unused_word = ^word_i;

endmodule

// File: tb/tb_lw_sha_round_ctrl.sv
// Bench for lw_sha_round_ctrl: real SHA-256/512 "abc" rounds around two controller instances.
module tb_lw_sha_round_ctrl;

  localparam logic [63:0] K512 [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // Index 7 is word a; SHA-256 uses the upper halves.
  localparam logic [63:0] IV512 [0:7] = '{
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b, 64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b, 64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
  };

  localparam logic [255:0] EXP256 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] EXP512 = {
    256'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a,
    256'h2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f};

`ifdef LW_SHA_RAND_REFRESH_EN
  localparam logic [1:0] REFRESH_MASK = 2'b11;
`else
  localparam logic [1:0] REFRESH_MASK = 2'b00;
`endif

  typedef struct {
    bit is512;
    bit mode;
    int stall_idx;
    int stall_len;
    int restart_idx;
    int exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst, abort, mode_m, sel512, start_m, valid_m;
  logic [63:0] word_m;
  logic [1:0]  rnd_m;

  always #5 clk = ~clk;

  logic            start32, valid32, ready32, busy32, done32;
  logic [31:0]     word32;
  logic [7:0][32:0] init32, rs32, new32, dg32;
  logic [6:0]      idx32;
  logic [1:0]      rr32, st32;

  logic            start64, valid64, ready64, busy64, done64;
  logic [63:0]     word64;
  logic [7:0][64:0] init64, rs64, new64, dg64;
  logic [6:0]      idx64;
  logic [1:0]      rr64, st64;

  logic       rdy_m, done_mx, busy_mx;
  logic [6:0] idx_m;
  logic [1:0] rndo_m;

  logic [31:0] s256 [0:63];
  logic [63:0] s512 [0:79];
  vec_t        vecs [7];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [7:0][32:0] round256(input logic [7:0][32:0] s,
                                                input logic [6:0] t, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, k;
    logic [63:0] kk;
    logic [7:0][32:0] r;
    a = s[7][31:0]; b = s[6][31:0]; c = s[5][31:0]; d = s[4][31:0];
    e = s[3][31:0]; f = s[2][31:0]; g = s[1][31:0]; h = s[0][31:0];
    kk = (t < 7'd64) ? K512[t] : 64'h0;
    k  = kk[63:32];
    t1 = h + (r32(e, 6) ^ r32(e, 11) ^ r32(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (r32(a, 2) ^ r32(a, 13) ^ r32(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    r[7] = {1'b0, t1 + t2}; r[6] = {1'b0, a}; r[5] = {1'b0, b}; r[4] = {1'b0, c};
    r[3] = {1'b0, d + t1};  r[2] = {1'b0, e}; r[1] = {1'b0, f}; r[0] = {1'b0, g};
    return r;
  endfunction

  function automatic logic [7:0][64:0] round512(input logic [7:0][64:0] s,
                                                input logic [6:0] t, input logic [63:0] w);
    logic [63:0] a, b, c, d, e, f, g, h, t1, t2, k;
    logic [7:0][64:0] r;
    a = s[7][63:0]; b = s[6][63:0]; c = s[5][63:0]; d = s[4][63:0];
    e = s[3][63:0]; f = s[2][63:0]; g = s[1][63:0]; h = s[0][63:0];
    k  = (t < 7'd80) ? K512[t] : 64'h0;
    t1 = h + (r64(e, 14) ^ r64(e, 18) ^ r64(e, 41)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (r64(a, 28) ^ r64(a, 34) ^ r64(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
    r[7] = {1'b0, t1 + t2}; r[6] = {1'b0, a}; r[5] = {1'b0, b}; r[4] = {1'b0, c};
    r[3] = {1'b0, d + t1};  r[2] = {1'b0, e}; r[1] = {1'b0, f}; r[0] = {1'b0, g};
    return r;
  endfunction

  assign start32 = start_m & ~sel512;
  assign valid32 = valid_m & ~sel512;
  assign word32  = word_m[31:0];
  assign start64 = start_m & sel512;
  assign valid64 = valid_m & sel512;
  assign word64  = word_m;
  assign new32   = round256(rs32, idx32, word32);
  assign new64   = round512(rs64, idx64, word64);
  assign rdy_m   = sel512 ? ready64 : ready32;
  assign done_mx = sel512 ? done64 : done32;
  assign busy_mx = sel512 ? busy64 : busy32;
  assign idx_m   = sel512 ? idx64 : idx32;
  assign rndo_m  = sel512 ? rr64 : rr32;

  lw_sha_round_ctrl #(.W(32), .SUPPORT_512(1'b0)) u_d32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .abort_i(abort), .mode_i(mode_m),
    .init_state_i(init32), .word_i(word32), .word_valid_i(valid32), .word_ready_o(ready32),
    .rnd_i(rnd_m), .rnd_state_o(rs32), .rnd_index_o(idx32), .rnd_random_o(rr32),
    .rnd_new_i(new32), .busy_o(busy32), .done_o(done32), .digest_o(dg32), .dbg_state_o(st32));

  lw_sha_round_ctrl #(.W(64), .SUPPORT_512(1'b1)) u_d64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .abort_i(abort), .mode_i(mode_m),
    .init_state_i(init64), .word_i(word64), .word_valid_i(valid64), .word_ready_o(ready64),
    .rnd_i(rnd_m), .rnd_state_o(rs64), .rnd_index_o(idx64), .rnd_random_o(rr64),
    .rnd_new_i(new64), .busy_o(busy64), .done_o(done64), .digest_o(dg64), .dbg_state_o(st64));

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Feed-forward of the unmasked final state against the published digest.
  task automatic check_digest(input string name, input bit is512);
    logic [511:0] act;
    logic [63:0]  iv;
    logic         msk;
    act = '0;
    msk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iv = IV512[i];
      if (is512) begin
        act[i*64 +: 64] = dg64[i][63:0] + iv;
        msk = msk | dg64[i][64];
      end else begin
        act[i*32 +: 32] = dg32[i][31:0] + iv[63:32];
        msk = msk | dg32[i][32];
      end
    end
    chk({name, "_digest"}, act, is512 ? EXP512 : {256'h0, EXP256});
    chk({name, "_mask_bits"}, {511'h0, msk}, 512'h0);
  endtask

  task automatic run_block(input vec_t v, input string tag);
    int rounds, t, stalled, done_k, dones;
    bit restarted, idx_ok, rdy_ok, rnd_ok, hs;
    logic [1:0] exp_rnd, nxt_rnd;
    rounds = v.is512 ? 80 : 64;
    @(posedge clk); #1;
    sel512  = v.is512;
    mode_m  = v.mode;
    rnd_m   = 2'($urandom_range(0, 3));
    start_m = 1'b1;
    valid_m = 1'b0;
    nxt_rnd = rnd_m & REFRESH_MASK;
    t = 0; stalled = 0; done_k = -1; dones = 0;
    restarted = 1'b0; idx_ok = 1'b1; rdy_ok = 1'b1; rnd_ok = 1'b1; hs = 1'b0;
    for (int k = 1; k <= rounds + v.stall_len + 12; k++) begin
      @(posedge clk); #1;
      start_m = 1'b0;
      if (hs) t++;
      exp_rnd = nxt_rnd;
      rnd_m   = 2'($urandom_range(0, 3));
      mode_m  = 1'($urandom_range(0, 1));
      valid_m = 1'b0;
      if (t < rounds) begin
        word_m = v.is512 ? s512[t] : {32'h0, s256[t]};
        if (t == v.stall_idx && stalled < v.stall_len) stalled++;
        else valid_m = 1'b1;
        if (t == v.restart_idx && !restarted) begin
          start_m   = 1'b1;
          restarted = 1'b1;
        end
      end
      @(negedge clk);
      if (t < rounds && idx_m !== 7'(t)) idx_ok = 1'b0;
      if (rdy_m !== (t < rounds)) rdy_ok = 1'b0;
      if (rndo_m !== exp_rnd) rnd_ok = 1'b0;
      hs = valid_m & rdy_m;
      if (hs) nxt_rnd = rnd_m & REFRESH_MASK;
      if (done_mx) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
    end
    valid_m = 1'b0;
    chk({tag, "_done_latency"}, done_k, v.exp_lat);
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_handshakes"}, t, rounds);
    chk({tag, "_index_track"}, idx_ok, 1);
    chk({tag, "_ready_track"}, rdy_ok, 1);
    chk({tag, "_rnd_random"}, rnd_ok, 1);
    chk({tag, "_busy_end"}, busy_mx, 0);
    check_digest(tag, v.is512);
  endtask

  // Starts a SHA-256 block on the 32-bit instance and returns in the cycle where index==n.
  task automatic start_to(input int n);
    @(posedge clk); #1;
    sel512 = 1'b0; mode_m = 1'b0; start_m = 1'b1; valid_m = 1'b0;
    @(posedge clk); #1;
    start_m = 1'b0;
    for (int t = 0; t < n; t++) begin
      valid_m = 1'b1;
      word_m  = {32'h0, s256[t]};
      @(posedge clk); #1;
    end
    valid_m = 1'b1;
    word_m  = {32'h0, s256[n]};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [63:0] iv;
    rst = 1'b1; abort = 1'b0; mode_m = 1'b0; sel512 = 1'b0;
    start_m = 1'b0; valid_m = 1'b0; word_m = '0; rnd_m = 2'b00;
    for (int i = 0; i < 8; i++) begin
      iv = IV512[i];
      init32[i] = {1'b0, iv[63:32]};
      init64[i] = {1'b0, iv};
    end
    for (int t = 0; t < 64; t++) s256[t] = 32'h0;
    for (int t = 0; t < 80; t++) s512[t] = 64'h0;
    s256[0] = 32'h61626380; s256[15] = 32'h18;
    s512[0] = 64'h6162638000000000; s512[15] = 64'h18;
    for (int t = 16; t < 64; t++)
      s256[t] = s256[t-16] + s256[t-7]
              + (r32(s256[t-15], 7) ^ r32(s256[t-15], 18) ^ (s256[t-15] >> 3))
              + (r32(s256[t-2], 17) ^ r32(s256[t-2], 19) ^ (s256[t-2] >> 10));
    for (int t = 16; t < 80; t++)
      s512[t] = s512[t-16] + s512[t-7]
              + (r64(s512[t-15], 1) ^ r64(s512[t-15], 8) ^ (s512[t-15] >> 7))
              + (r64(s512[t-2], 19) ^ r64(s512[t-2], 61) ^ (s512[t-2] >> 6));

    vecs[0] = '{1'b0, 1'b0, -1, 0, -1, 65};
    vecs[1] = '{1'b0, 1'b0, 10, 3, -1, 68};
    vecs[2] = '{1'b1, 1'b1, -1, 0, -1, 81};
    vecs[3] = '{1'b0, 1'b1,  0, 1, -1, 66};
    vecs[4] = '{1'b0, 1'b0, 63, 2, -1, 67};
    vecs[5] = '{1'b0, 1'b0, -1, 0,  5, 65};
    vecs[6] = '{1'b1, 1'b1, 79, 1, -1, 82};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl32", {busy32, done32, ready32, idx32, rr32, st32}, 0);
    chk("reset_ctrl64", {busy64, done64, ready64, idx64, rr64, st64}, 0);
    chk("reset_state32", {rs32, dg32}, 0);
    chk("reset_state64", {rs64, dg64}, 0);

    for (int i = 0; i < 7; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    start_to(20);
    chk("abort_pre_index", idx32, 20);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; valid_m = 1'b0;
    chk("abort_busy", busy32, 0);
    chk("abort_ready", ready32, 0);
    chk("abort_index", idx32, 0);
    chk("abort_state", dg32, 0);
    dones = 0;
    repeat (70) begin
      @(negedge clk);
      if (done32) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_block(vecs[0], "after_abort");

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      valid_m = 1'b1;
      word_m  = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_word_ready", ready32, 0);
    end
    valid_m = 1'b0;
    chk("idle_index_no_wrap", idx32, 63);
    check_digest("idle_hold", 1'b0);

    @(posedge clk); #1;
    start_m = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy32, 0);
    chk("start_abort_ready", ready32, 0);
    check_digest("start_abort_hold", 1'b0);

    start_to(30);
    chk("rst_pre_index", idx32, 30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid_m = 1'b0;
    chk("rst_mid_ctrl32", {busy32, done32, ready32, idx32, rr32, st32}, 0);
    chk("rst_mid_state32", {rs32, dg32}, 0);
    chk("rst_mid_digest64", dg64, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
